// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter for the shared data-memory port
module data_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [1:0]  i_mask0,
  input  logic [1:0]  i_mask1,
  output logic        o_done0,
  output logic        o_done1,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [1:0]  o_mem_mask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_winner;
  logic             owner;
  logic             winner;
  logic             grant;
  logic             timeout_hit;
  logic             finish;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_we;
  logic [1:0]       sel_mask;

  // Arbitration: a lone requester wins outright, a tie goes to the port that did not win last
  always_comb begin
    grant     = i_req0 | i_req1;
    winner    = 1'b0;
    if (i_req0 && i_req1) begin
      winner = ~last_winner;
    end else begin
      winner = i_req1;
    end
    sel_addr  = winner ? i_addr1  : i_addr0;
    sel_wdata = winner ? i_wdata1 : i_wdata0;
    sel_we    = winner ? i_we1    : i_we0;
    sel_mask  = winner ? i_mask1  : i_mask0;
  end

  // A WAIT cycle ends the transaction on ack, or on the last watchdog count (ack has priority)
  always_comb begin
    timeout_hit = (cnt == CNT_LAST);
    finish      = (state == WAIT) && (i_mem_ack || timeout_hit);
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: grant leaves IDLE, completion or timeout leaves WAIT, RESP always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)  state_nxt = WAIT;
      WAIT:    if (finish) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered payload, memory handshake, watchdog and response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_winner <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      o_done0     <= 1'b0;
      o_done1     <= 1'b0;
      o_rdata     <= '0;
      o_err       <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_mask  <= '0;
    end else begin
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner       <= winner;
            last_winner <= winner;
            cnt         <= '0;
            o_mem_req   <= 1'b1;
            o_mem_addr  <= sel_addr;
            o_mem_wdata <= sel_wdata;
            o_mem_we    <= sel_we;
            o_mem_re    <= ~sel_we;
            o_mem_mask  <= sel_mask;
          end
        end
        WAIT: begin
          if (finish) begin
            o_mem_req <= 1'b0;
            o_mem_re  <= 1'b0;
            o_done0   <= ~owner;
            o_done1   <= owner;
            if (i_mem_ack) begin
              o_rdata <= i_mem_rdata;
              o_err   <= 1'b0;
            end else begin
              o_rdata <= '0;
              o_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
